rast_span_emitter: RTL

- Rasterizer-side producer for the framebuffer pixel-write interface: the transmitter end of the link the framebuffer consumes.
- Accepts horizontal span commands (x0, x1, y, color) from rasterizer setup into a small FIFO.
- Serialises each span into one pixel write per handshake: drives color, x (rast_width) and y (rast_height), qualified by rast_pixel_rdy.
- Signals rast_done when the frame's last span has drained; a new frame starts on next_frame_switch from the clipping unit.

---
 rtl/rast_span_emitter_pkg.sv | 46 ++++
 rtl/rast_span_emitter_fifo.sv | 68 ++++++
 rtl/rast_span_emitter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rast_span_emitter_pkg.sv
// Shared definitions for the span emitter: field widths, screen defaults,
// the span record stored in the command FIFO and the emitter FSM states.
package rast_span_emitter_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int C_W          = 3;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Span record layout, MSB first: {last, color, y, x1, x0} = 33 bits.
    typedef struct packed {
        logic           last;
        logic [C_W-1:0] color;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x1;
        logic [X_W-1:0] x0;
    } span_t;

    localparam int SPAN_W = $bits(span_t);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EMIT    = 3'd2,
        ST_END_CHK = 3'd3,
        ST_DONE    = 3'd4
    } emit_state_t;

    // A span carries no pixels when its inclusive end lies left of its start.
    function automatic logic span_is_empty(input span_t s);
        return (s.x1 < s.x0);
    endfunction

    // Zero-pixel record that still carries the end-of-frame mark.
    function automatic span_t end_marker();
        span_t m;
        m.last  = 1'b1;
        m.color = 3'd0;
        m.y     = 9'd0;
        m.x1    = 10'd0;
        m.x0    = 10'd1;
        return m;
    endfunction

endpackage

// File: rtl/rast_span_emitter_fifo.sv
// Small synchronous FIFO holding span commands between rasterizer setup and
// the pixel serialiser. Pointers wrap naturally; count is one bit wider.
module rast_span_fifo
    import rast_span_emitter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  span_t                  push_data,
    input  logic                   pop,
    output span_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    span_t          mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           push_ok_s;
    logic           pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array: write the pushed record at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rast_span_emitter.sv
// Rasterizer-side producer for the framebuffer pixel-write link: buffers span
// commands, then serialises each span into one pixel per handshake and flags
// the end of the frame.
module rast_span_emitter
    import rast_span_emitter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           next_frame_switch,
    input  logic           span_valid,
    output logic           span_ready,
    input  logic [X_W-1:0] span_x0,
    input  logic [X_W-1:0] span_x1,
    input  logic [Y_W-1:0] span_y,
    input  logic [C_W-1:0] span_color,
    input  logic           span_last,
    input  logic           read_rast_pixel_rdy,
    output logic           rast_pixel_rdy,
    output logic [C_W-1:0] rast_color_input,
    output logic [X_W-1:0] rast_width,
    output logic [Y_W-1:0] rast_height,
    output logic           rast_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    emit_state_t    state_r;
    emit_state_t    next_state_s;
    span_t          span_in_s;
    span_t          fifo_out_s;
    logic           keep_s;
    logic           push_s;
    logic           pop_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [CW-1:0]  fifo_count_s;
    logic [X_W-1:0] x1_clamp_s;
    logic           load_s;
    logic           x_inc_s;
    logic           pend_set_s;
    logic           pend_clr_s;

    logic [X_W-1:0] x_r;
    logic [X_W-1:0] x1_r;
    logic [Y_W-1:0] y_r;
    logic [C_W-1:0] color_r;
    logic           last_r;
    logic           pixel_rdy_r;
    logic           done_r;
    logic           pending_r;

    assign span_ready       = (fifo_count_s != CW'(FIFO_DEPTH));
    assign push_s           = span_valid & ~fifo_full_s & keep_s;
    assign rast_pixel_rdy   = pixel_rdy_r;
    assign rast_color_input = color_r;
    assign rast_width       = x_r;
    assign rast_height      = y_r;
    assign rast_done        = done_r;

    // Push filter: clamp x1, drop off-screen lines but keep their end-of-frame mark.
    always_comb begin
        span_in_s  = '0;
        keep_s     = 1'b0;
        x1_clamp_s = span_x1;
        if (span_x1 >= X_W'(SCREEN_W)) begin
            x1_clamp_s = X_W'(SCREEN_W - 1);
        end else begin
            x1_clamp_s = span_x1;
        end
        if (span_y >= Y_W'(SCREEN_H)) begin
            keep_s    = span_last;
            span_in_s = end_marker();
        end else begin
            keep_s          = 1'b1;
            span_in_s.last  = span_last;
            span_in_s.color = span_color;
            span_in_s.y     = span_y;
            span_in_s.x1    = x1_clamp_s;
            span_in_s.x0    = span_x0;
        end
    end

    rast_span_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (span_in_s),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Next-state and control decode for the span serialiser.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        x_inc_s      = 1'b0;
        pend_set_s   = 1'b0;
        pend_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (next_frame_switch) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                pend_set_s = next_frame_switch;
                if (!fifo_empty_s) begin
                    pop_s  = 1'b1;
                    load_s = 1'b1;
                    if (span_is_empty(fifo_out_s)) begin
                        next_state_s = ST_END_CHK;
                    end else begin
                        next_state_s = ST_EMIT;
                    end
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EMIT: begin
                pend_set_s = next_frame_switch;
                if (read_rast_pixel_rdy) begin
                    if (x_r == x1_r) begin
                        next_state_s = ST_END_CHK;
                    end else begin
                        x_inc_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            ST_END_CHK: begin
                pend_set_s = next_frame_switch;
                if (last_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (next_frame_switch || pending_r) begin
                    next_state_s = ST_FETCH;
                    pend_clr_s   = 1'b1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Current span and presented pixel: load on pop, step x on each accepted pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r     <= 10'd0;
            x1_r    <= 10'd0;
            y_r     <= 9'd0;
            color_r <= 3'd0;
            last_r  <= 1'b0;
        end else if (load_s) begin
            x_r     <= fifo_out_s.x0;
            x1_r    <= fifo_out_s.x1;
            y_r     <= fifo_out_s.y;
            color_r <= fifo_out_s.color;
            last_r  <= fifo_out_s.last;
        end else if (x_inc_s) begin
            x_r <= x_r + 10'd1;
        end
    end

    // Registered handshake/status flags and the deferred-frame request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_rdy_r <= 1'b0;
            done_r      <= 1'b0;
            pending_r   <= 1'b0;
        end else begin
            pixel_rdy_r <= (next_state_s == ST_EMIT);
            done_r      <= (next_state_s == ST_DONE);
            if (pend_clr_s) begin
                pending_r <= 1'b0;
            end else if (pend_set_s) begin
                pending_r <= 1'b1;
            end
        end
    end

endmodule
